// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute/memory/writeback sequencer with branch resolution,
// a sticky halt, and an instruction counter.
module cpu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        dmem_ack,
    input  logic [3:0]  break_flag,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    output logic [15:0] ir,
    output logic [26:0] opcode_onehot,
    output logic        exec_en,
    output logic        wb_en,
    output logic        dmem_req,
    output logic [7:0]  pc,
    output logic [15:0] instr_count,
    output logic        halted,
    output logic        illegal
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state, state_nx;
    logic [4:0] op;
    logic taken, taken_nx;
    assign op = ir[15:11];
    assign imem_req = state == FETCH;
    assign imem_addr = pc;
    assign exec_en = state == EXEC;
    assign dmem_req = state == MEM;
    assign wb_en = state == WB;
    assign halted = state == HALT;
    assign taken_nx = (op == 5'd23) | (op == 5'd19 & break_flag[3]) | (op == 5'd20 & break_flag[2])
                    | (op == 5'd21 & break_flag[1]) | (op == 5'd22 & break_flag[0]);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = run ? FETCH : IDLE;
            FETCH:   state_nx = imem_ack ? DECODE : FETCH;
            DECODE:  state_nx = op > 5'd26 ? HALT : EXEC;
            EXEC:    state_nx = op == 5'd26 ? HALT : (op == 5'd12 || op == 5'd13) ? MEM : WB;
            MEM:     state_nx = dmem_ack ? WB : MEM;
            WB:      state_nx = run ? FETCH : IDLE;
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end
    // The decoded opcode lives only while an instruction is in EXEC/MEM/WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= '0;
            ir            <= '0;
            opcode_onehot <= '0;
            instr_count   <= '0;
            illegal       <= 1'b0;
            taken         <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == FETCH && imem_ack)
                ir <= imem_rdata;
            opcode_onehot <= (state == DECODE && state_nx == EXEC) ? 27'd1 << op :
                             (state_nx == EXEC || state_nx == MEM || state_nx == WB) ? opcode_onehot : '0;
            if (state == DECODE && op > 5'd26)
                illegal <= 1'b1;
            if (state == EXEC)
                taken <= taken_nx;
            if (state == WB) begin
                pc          <= pc + (taken ? ir[7:0] : 8'd1);
                instr_count <= instr_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed program run through cpu_sequencer; writeback results are
// checked by a scoreboard monitor against expectations queued at fetch time.
module tb_cpu_sequencer;
    logic clk = 0, rst_n = 0, run = 0, imem_ack = 0, dmem_ack = 0;
    logic [15:0] imem_rdata = 0;
    logic [3:0] break_flag = 0;
    logic imem_req, exec_en, wb_en, dmem_req, halted, illegal;
    logic [7:0] imem_addr, pc;
    logic [15:0] ir, instr_count;
    logic [26:0] opcode_onehot;
    int tests = 0, fails = 0;
    logic [7:0] mpc = 0;
    typedef struct { logic [26:0] oh; logic [7:0] pc; logic [15:0] cnt; } exp_t;
    exp_t q[$];

    cpu_sequencer dut (.clk(clk), .rst_n(rst_n), .run(run), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_ack(dmem_ack), .break_flag(break_flag), .imem_req(imem_req), .imem_addr(imem_addr), .ir(ir),
        .opcode_onehot(opcode_onehot), .exec_en(exec_en), .wb_en(wb_en), .dmem_req(dmem_req), .pc(pc),
        .instr_count(instr_count), .halted(halted), .illegal(illegal));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on each writeback, checks pc/count after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("mutex", 32'($countones({exec_en, wb_en, imem_req, dmem_req}) <= 1), 1);
            if (wb_en) begin
                if (q.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("wb_onehot", opcode_onehot, e.oh);
                    @(negedge clk);
                    chk("wb_pc", pc, e.pc);
                    chk("wb_count", instr_count, e.cnt);
                end
            end
        end
    end

    task automatic do_instr(input logic [15:0] w, input logic [3:0] f, input int dd, input logic drop_run,
                            input logic [7:0] epc, input logic [15:0] ecnt);
        logic [4:0] op;
        int n;
        op = w[15:11];
        run = 1;
        n = 0;
        while (!imem_req && n < 20) begin @(negedge clk); n++; end
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, mpc);
        imem_rdata = w; imem_ack = 1; break_flag = f;
        if (op < 26) q.push_back('{27'd1 << op, epc, ecnt});
        @(negedge clk);
        imem_ack = 0; imem_rdata = 16'hFFFF;
        if (drop_run) run = 0;
        chk("decode_ir", ir, w);
        chk("decode_quiet", {exec_en, wb_en, imem_req, dmem_req}, 0);
        @(negedge clk);
        if (op > 26) begin
            chk("illegal", illegal, 1);
            chk("illegal_halted", halted, 1);
            chk("illegal_onehot", opcode_onehot, 0);
            chk("illegal_noexec", exec_en, 0);
            return;
        end
        chk("exec_en", exec_en, 1);
        chk("exec_onehot", opcode_onehot, 27'd1 << op);
        @(negedge clk);
        break_flag = ~f;
        if (op == 26) begin
            chk("hlt_halted", halted, 1);
            chk("hlt_onehot", opcode_onehot, 0);
            chk("hlt_pc", pc, mpc);
            return;
        end
        if (op == 12 || op == 13) begin
            for (int i = 0; i < dd; i++) begin chk("mem_stall", dmem_req, 1); @(negedge clk); end
            chk("mem_req", dmem_req, 1);
            dmem_ack = 1;
            @(negedge clk);
            dmem_ack = 0;
        end
        chk("wb_en", wb_en, 1);
        chk("exec_once", exec_en, 0);
        @(negedge clk);
        chk("wb_once", wb_en, 0);
        mpc = epc;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 0;
        #1 chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        @(negedge clk);
        rst_n = 1;
        mpc = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("reset_pc", pc, 0);
        chk("reset_cnt", instr_count, 0);
        chk("reset_ir", ir, 0);
        chk("reset_onehot", opcode_onehot, 0);
        chk("reset_flags", {halted, illegal, imem_req, dmem_req, exec_en, wb_en}, 0);
        repeat (3) @(negedge clk);
        chk("idle_no_req", imem_req, 0);
        do_instr(16'h3800, 4'h0, 0, 0, 8'd1, 16'd1);    // ADD
        do_instr(16'h6800, 4'h0, 3, 1, 8'd2, 16'd2);    // STORE, stall 3, run dropped
        do_instr(16'hB808, 4'h0, 0, 0, 8'd10, 16'd3);   // JMP +8
        do_instr(16'h98FB, 4'b1000, 0, 0, 8'd5, 16'd4); // op19 taken
        do_instr(16'hB805, 4'h0, 0, 0, 8'd10, 16'd5);
        do_instr(16'h98FB, 4'b0100, 0, 0, 8'd11, 16'd6); // op19 not taken
        do_instr(16'hB8FF, 4'h0, 0, 0, 8'd10, 16'd7);
        do_instr(16'hA8FB, 4'b0010, 0, 0, 8'd5, 16'd8); // op21 taken
        do_instr(16'hB8FA, 4'h0, 0, 0, 8'd255, 16'd9);
        do_instr(16'h3800, 4'h0, 0, 0, 8'd0, 16'd10);   // wrap
        do_instr(16'h6000, 4'h0, 0, 0, 8'd1, 16'd11);   // LOAD, no stall
        do_instr(16'hD000, 4'h0, 0, 0, 8'd1, 16'd11);   // HLT
        for (int i = 0; i < 6; i++) begin
            run = ~run; imem_ack = 1; dmem_ack = 1;
            @(negedge clk);
        end
        imem_ack = 0; dmem_ack = 0;
        chk("halt_sticky", halted, 1);
        chk("halt_pc", pc, 1);
        chk("halt_cnt", instr_count, 11);
        chk("halt_quiet", {imem_req, dmem_req, exec_en, wb_en}, 0);
        pulse_reset();
        do_instr(16'hF000, 4'h0, 0, 0, 8'd0, 16'd0);    // illegal op30
        @(negedge clk);
        chk("illegal_sticky", {halted, illegal}, 2'b11);
        pulse_reset();
        do_instr(16'h3800, 4'h0, 0, 0, 8'd1, 16'd1);
        run = 1;
        while (!imem_req) @(negedge clk);
        imem_rdata = 16'h6800; imem_ack = 1;
        @(negedge clk);
        imem_ack = 0;
        repeat (2) @(negedge clk);
        chk("mem_before_rst", dmem_req, 1);
        #2 rst_n = 0;
        #1 chk("rst_dmem_req", dmem_req, 0);
        chk("rst_mem_pc", pc, 0);
        chk("rst_mem_cnt", instr_count, 0);
        chk("rst_mem_ir", ir, 0);
        chk("rst_mem_onehot", opcode_onehot, 0);
        chk("rst_mem_flags", {halted, illegal, imem_req, exec_en, wb_en}, 0);
        @(negedge clk);
        run = 0; rst_n = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {imem_req, dmem_req}, 0);
        chk("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 The block SHALL provide these inputs:
- run (1): enables instruction execution.
- imem_ack (1): instruction memory data valid.
- imem_rdata (16): instruction word; [15:11] opcode, [7:0] signed branch offset.
- dmem_ack (1): data memory access complete.
- break_flag (4): ALU condition flags B4..B1.
REQ-003 The block SHALL provide these outputs:
- imem_req (1), imem_addr (8, equals pc).
- ir (16): instruction register.
- opcode_onehot (27): decoded opcode to control_unit.
- exec_en (1), wb_en (1), dmem_req (1).
- pc (8), instr_count (16), halted (1), illegal (1).

Function
REQ-004 The FSM SHALL have seven states: IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-005 In IDLE, run=1 SHALL cause a transition to FETCH on the next edge; otherwise the FSM stays in IDLE.
REQ-006 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held until imem_ack=1.
- On that edge ir SHALL load imem_rdata and the FSM SHALL go to DECODE.
REQ-007 imem_ack and dmem_ack SHALL be ignored in every state other than FETCH and MEM respectively.
REQ-008 In DECODE, opcode_onehot SHALL be registered as a one-hot of ir[15:11], visible from EXEC onward.
- Opcodes 27..31 SHALL drive opcode_onehot to 0, set illegal=1 and go to HALT.
- All other opcodes SHALL go to EXEC.
REQ-009 opcode_onehot SHALL stay stable through EXEC, MEM and WB, and SHALL be 0 in IDLE, FETCH and HALT.
REQ-010 In EXEC, exec_en SHALL be 1 for exactly one cycle, and the next state SHALL be:
- HALT for opcode 26 (HLT);
- MEM for opcode 12 (LOAD) or 13 (STORE);
- WB for all other opcodes.
REQ-011 Branch taken SHALL be registered in EXEC from break_flag as follows:
- opcode 19 uses B4 (break_flag[3]);
- opcode 20 uses B3 ([2]);
- opcode 21 uses B2 ([1]);
- opcode 22 uses B1 ([0]);
- opcode 23 (JMP) is always taken;
- all other opcodes are not taken.
REQ-012 In MEM, dmem_req SHALL be 1 until dmem_ack=1, then the FSM SHALL go to WB; with no ack, MEM SHALL hold indefinitely.
REQ-013 In WB, wb_en SHALL be 1 for one cycle, and on that edge:
- pc SHALL become pc + sign-extended ir[7:0] if taken, else pc+1, modulo 256 (wrap 255->0);
- instr_count SHALL increment, wrapping 65535->0.
REQ-014 From WB, the FSM SHALL go to FETCH if run=1, else IDLE.
- run=0 in any other state SHALL NOT abort the instruction in progress.
REQ-015 HALT SHALL be sticky until reset: halted=1, and all request and enable outputs SHALL be 0.
- A HLT instruction SHALL NOT advance pc or instr_count.
REQ-016 Minimum instruction latency SHALL be:
- 4 cycles for non-memory instructions (imem_ack in the first FETCH cycle);
- 5 cycles for LOAD/STORE (both acks in the first cycle).
REQ-017 exec_en, wb_en, imem_req and dmem_req SHALL be mutually exclusive in every cycle.

Reset
REQ-018 On rst_n=0, the block SHALL immediately and asynchronously force:
- state to IDLE;
- pc, ir, opcode_onehot and instr_count to 0;
- imem_req, dmem_req, exec_en, wb_en, halted, illegal and the taken flag to 0.
REQ-019 A reset asserted mid-FETCH or mid-MEM SHALL drop the pending request in the same cycle, with no further access issued until run is seen in IDLE.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ADD: run=1, opcode 7 at pc=0, imem_ack immediate -> exec_en 3rd cycle, wb_en 4th, pc=1, instr_count=1, opcode_onehot=27'h80 during EXEC/WB.
- STORE with stall: opcode 13, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, single wb_en, pc +1.
- Branches at pc=10, offset 8'hFB: opcode 19 with break_flag=4'b1000 -> pc=5; same with break_flag=4'b0100 -> pc=11; opcode 21 with 4'b0010 -> pc=5.
- Wrap and halt: pc=255, opcode 7 -> pc=0. Opcode 26 -> halted=1, pc unchanged; run toggling has no effect until reset.
- Illegal opcode 30 -> illegal=1, halted=1, opcode_onehot=0.
- rst_n pulsed low during MEM -> dmem_req=0 same cycle, all outputs at reset values.
